// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared types, defaults and helpers for the serial-in parallel-out receiver
package sipo_pkg;

  // Receiver state: waiting for the first sync, or collecting frames
  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } sipo_state_e;

  localparam int SIPO_DEFAULT_WIDTH = 4;

  // Bit counter width: must hold WIDTH itself, used as the parity bit index
  function automatic int sipo_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// rtl/sipo_bit_counter.sv - frame bit counter with sync restart and last-bit / parity-slot flags
module sipo_bit_counter
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_DEFAULT_WIDTH,
  parameter int CW    = sipo_cnt_width(WIDTH)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sync,
  input  logic strobe,
  input  logic parity_len,
  output logic last,
  output logic parity_slot
);

  logic [CW-1:0] count;
  logic [CW-1:0] last_idx;

  // Frame length grows by one when a parity bit trails the data bits
  assign last_idx = parity_len ? CW'(WIDTH) : CW'(WIDTH - 1);

  // A bit arriving together with sync is bit 0 of the new frame, never the last bit
  always_comb begin
    last        = strobe && !sync && (count == last_idx);
    parity_slot = strobe && !sync && parity_len && (count == CW'(WIDTH));
  end

  // Count accepted bits; sync restarts the frame, completion wraps to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (sync) begin
      count <= strobe ? CW'(1) : '0;
    end else if (strobe) begin
      count <= last ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// rtl/sipo_deserializer.sv - serial-to-parallel receiver with held output word; SIPO_PARITY_CHECK_EN adds even parity
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_en,
  input  logic             sync,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
`ifdef SIPO_PARITY_CHECK_EN
  output logic             parity_err,
`endif
  input  logic             overrun_clr
);

  localparam int CW = sipo_cnt_width(WIDTH);

`ifdef SIPO_PARITY_CHECK_EN
  localparam logic PARITY_LEN = 1'b1;
`else
  localparam logic PARITY_LEN = 1'b0;
`endif

  sipo_state_e      state;
  sipo_state_e      state_nxt;
  logic             accept;
  logic             last;
  logic             parity_slot;
  logic             shift;
  logic             load;
  logic             drop;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] word;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: the first sync starts reception, after which frames run back to back
  always_comb begin
    state_nxt = state;
    if (state == HUNT && sync) begin
      state_nxt = RECV;
    end
  end

  // Output decode: a strobe counts while receiving, or in HUNT when it comes with sync
  always_comb begin
    accept = 1'b0;
    if (sin_en && (state == RECV || sync)) begin
      accept = 1'b1;
    end
  end

  sipo_bit_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_bit_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .sync        (sync),
    .strobe      (accept),
    .parity_len  (PARITY_LEN),
    .last        (last),
    .parity_slot (parity_slot)
  );

  assign q_next = {sin, q[WIDTH-1:1]};
  assign shift  = accept && !parity_slot;

  // With parity the data is already complete in q when the parity bit arrives
`ifdef SIPO_PARITY_CHECK_EN
  assign word = q;
`else
  assign word = q_next;
`endif

  assign load = last && (!dout_valid || dout_ready);
  assign drop = last && dout_valid && !dout_ready;

  // Shift register: new bits enter the MSB so the first bit ends in bit 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (shift) begin
      q <= q_next;
    end
  end

  // Holding register: a completed word replaces an accepted or empty slot, otherwise it is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (load) begin
      dout       <= word;
      dout_valid <= 1'b1;
    end else if (dout_valid && dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

  // Sticky overrun: a drop in the same cycle as a clear keeps the flag set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

`ifdef SIPO_PARITY_CHECK_EN
  // Parity status travels with the held word; dropped words leave it alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
    end else if (load) begin
      parity_err <= (^q) ^ sin;
    end else if (dout_valid && dout_ready) begin
      parity_err <= 1'b0;
    end
  end
`endif

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
- Receive end of the team's serial shift-register link: collects a serial bit stream (sin, qualified by sin_en) into WIDTH-bit parallel words.
- Bits shift right: each new bit enters the MSB, so the first bit of a frame lands in bit 0.
- Completed words pass through a one-entry holding register with a valid/ready handshake.
- Sits downstream of any serial-out shift register driving the same one-bit line.

Parameters:
- WIDTH, 4, data bits per frame (2..32).

Ports:
- clk  input  1  system clock, all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- sin  input  1  serial data bit.
- sin_en  input  1  bit strobe; sin sampled only when 1.
- sync  input  1  frame start; clears the bit counter.
- q  output  WIDTH  live shift register contents.
- dout  output  WIDTH  held parallel word.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout when valid and ready are both 1.
- overrun  output  1  sticky flag: a completed word was dropped.
- overrun_clr  input  1  clears overrun.

Behaviour:
- Reset (rst_n=0, async): q=0, dout=0, dout_valid=0, overrun=0, bit counter=0, FSM=HUNT.
- FSM states:
  - HUNT: ignores sin_en until sync=1. sync goes to RECV.
  - RECV: shifts on each sin_en: q <= {sin, q[WIDTH-1:1]}, count+1.
- sync handling:
  - sync=1 with sin_en=1: count restarts; this bit is bit 0 (count becomes 1).
  - sync=1 with sin_en=0: count=0, no shift.
  - sync mid-frame discards the partial frame silently; q is not cleared.
- Frame complete: the edge that samples bit WIDTH-1 (count==WIDTH-1 and sin_en=1):
  - count wraps to 0; FSM stays in RECV, so back-to-back frames need no new sync.
  - The completed word (new q value) is transferred to dout at that same edge.
- Holding register (evaluated at the completion edge):
  - dout_valid=0: load dout, dout_valid=1.
  - dout_valid=1 and dout_ready=1: load the new word, dout_valid stays 1, no overrun.
  - dout_valid=1 and dout_ready=0: new word dropped, old dout retained, overrun<=1.
- Latency: dout_valid is high in the cycle after the edge sampling the last bit.
- Handshake: dout_valid and dout are stable until accepted. On accept with no completion in the same cycle, dout_valid<=0 and dout retains its value.
- overrun: sticky. overrun_clr=1 clears it; if a set and a clear occur in the same cycle, set wins.
- Reset mid-frame: everything returns to reset values immediately; the partial frame is lost.

Optional Feature:
- Macro: SIPO_PARITY_CHECK_EN.
- Defined:
  - Each frame carries one extra even-parity bit after the WIDTH data bits; count runs to WIDTH.
  - The parity bit is not shifted into q.
  - Output port parity_err (1 bit) is added. It is registered with dout at the word load: 1 if XOR(data bits, parity bit) is 1. It clears on accept.
  - A dropped word does not affect parity_err.
- Undefined: no parity bit, no parity_err port; frame = WIDTH bits exactly.

Decomposition:
- Package sipo_pkg:
  - state enum typedef (HUNT, RECV).
  - SIPO_DEFAULT_WIDTH=4.
  - function for counter width (clog2 of WIDTH+1).
- One sub-module, sipo_bit_counter:
  - counts sin_en, clears on sync, flags the last bit.
  - has a parity-length input.
- Shift register, holding register and flags stay in the top module.

Test Plan:
- Reset, then sync with sin_en, bits 1,0,1,1 on consecutive cycles, dout_ready=1 -> dout=4'b1101, dout_valid high for exactly one cycle after the 4th bit edge, q=4'b1101.
- Two back-to-back frames 1,1,0,0 then 0,1,0,1, sync only before the first, dout_ready=0 -> dout=4'b0011 stays held, overrun=1 after the second frame; overrun_clr pulse -> overrun=0.
- Same two frames with dout_ready=1 on the completion cycle of frame 2 -> dout=4'b1010, dout_valid=1, overrun=0.
- sin_en gaps (strobe every 3rd cycle) plus sync after 2 bits of a frame, then bits 0,0,0,1 -> partial frame discarded, dout=4'b1000.
- rst_n pulled low mid-frame after 2 bits, released, then sync + 1,1,1,1 -> all outputs 0 during reset, then dout=4'b1111.
- With SIPO_PARITY_CHECK_EN: data 1,0,1,1 + parity 1 -> parity_err=0; data 1,0,1,1 + parity 0 -> parity_err=1.
